wb_cpu_arbiter: RTL and testbench

//  Two-master to one-slave pipelined Wishbone arbiter downstream of the bexkat2 core.

---
 rtl/wb_cpu_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wb_cpu_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cpu_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter.
// Merges the core's instruction and data buses onto one memory bus. The
// winning master owns the bus for its whole cyc, and every ack is routed to
// the master that issued the request it answers.
//
//  state  | meaning
//  -------+------------------------------------------------------------
//  S_IDLE | no grant; both masters stalled, arbitration on cyc&stb
//  S_INS  | instruction bus owns the memory bus
//  S_DAT  | data bus owns the memory bus
module wb_cpu_arbiter #(
    parameter bit DAT_PRIORITY    = 1'b1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // instruction master
    input  logic        ins_cyc,
    input  logic        ins_stb,
    input  logic        ins_we,
    input  logic [3:0]  ins_sel,
    input  logic [31:0] ins_adr,
    input  logic [31:0] ins_wdat,
    output logic        ins_ack,
    output logic        ins_stall,
    output logic [31:0] ins_rdat,
    // data master
    input  logic        dat_cyc,
    input  logic        dat_stb,
    input  logic        dat_we,
    input  logic [3:0]  dat_sel,
    input  logic [31:0] dat_adr,
    input  logic [31:0] dat_wdat,
    output logic        dat_ack,
    output logic        dat_stall,
    output logic [31:0] dat_rdat,
    // memory slave
    output logic        mem_cyc,
    output logic        mem_stb,
    output logic        mem_we,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdat,
    input  logic        mem_ack,
    input  logic        mem_stall,
    input  logic [31:0] mem_rdat,
    // debug
    output logic [1:0]  owner
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_INS  = 2'b01,
        S_DAT  = 2'b10
    } state_t;

    state_t      state;
    state_t      last_owner;
    logic [3:0]  count;

    logic        o_cyc;
    logic        o_stb;
    logic        o_we;
    logic [3:0]  o_sel;
    logic [31:0] o_adr;
    logic [31:0] o_wdat;

    logic        has_owner;
    logic        at_limit;
    logic        accept;
    logic        fwd_ack;
    logic        ins_req;
    logic        dat_req;

    assign ins_req = ins_cyc & ins_stb;
    assign dat_req = dat_cyc & dat_stb;

    // Select the current owner's request signals; all zero while idle.
    always_comb begin
        o_cyc  = 1'b0;
        o_stb  = 1'b0;
        o_we   = 1'b0;
        o_sel  = 4'd0;
        o_adr  = 32'd0;
        o_wdat = 32'd0;
        case (state)
            S_INS: begin
                o_cyc  = ins_cyc;
                o_stb  = ins_stb;
                o_we   = ins_we;
                o_sel  = ins_sel;
                o_adr  = ins_adr;
                o_wdat = ins_wdat;
            end
            S_DAT: begin
                o_cyc  = dat_cyc;
                o_stb  = dat_stb;
                o_we   = dat_we;
                o_sel  = dat_sel;
                o_adr  = dat_adr;
                o_wdat = dat_wdat;
            end
            default: ;
        endcase
    end

    assign has_owner = (state == S_INS) || (state == S_DAT);
    assign at_limit  = (count == MAX_CNT);

    assign mem_cyc  = o_cyc;
    assign mem_stb  = o_stb & (count < MAX_CNT);
    assign mem_we   = o_we;
    assign mem_sel  = o_sel;
    assign mem_adr  = o_adr;
    assign mem_wdat = o_wdat;

    // Acks with nothing outstanding, or arriving after the owner has let go
    // of cyc, belong to no live request and are swallowed here.
    assign accept  = mem_stb & ~mem_stall;
    assign fwd_ack = has_owner & o_cyc & mem_ack & (count != 4'd0);

    assign ins_ack   = fwd_ack & (state == S_INS);
    assign ins_stall = (state != S_INS) | mem_stall | at_limit;
    assign ins_rdat  = (state == S_INS) ? mem_rdat : 32'd0;

    assign dat_ack   = fwd_ack & (state == S_DAT);
    assign dat_stall = (state != S_DAT) | mem_stall | at_limit;
    assign dat_rdat  = (state == S_DAT) ? mem_rdat : 32'd0;

    assign owner = state;

    // Grant / release sequencing and outstanding-request tracking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            last_owner <= S_DAT;
            count      <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    count <= 4'd0;
                    if (ins_req && dat_req) begin
                        state <= (DAT_PRIORITY || last_owner == S_INS) ? S_DAT : S_INS;
                    end else if (dat_req) begin
                        state <= S_DAT;
                    end else if (ins_req) begin
                        state <= S_INS;
                    end
                end
                S_INS, S_DAT: begin
                    if (!o_cyc) begin
                        state      <= S_IDLE;
                        last_owner <= state;
                        count      <= 4'd0;
                    end else if (accept && !fwd_ack) begin
                        count <= count + 4'd1;
                    end else if (!accept && fwd_ack) begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    count <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cpu_arbiter.sv
// Bench for wb_cpu_arbiter: two instances (data priority and round-robin)
// share one stimulus; a per-instance behavioural model predicts every output
// each cycle, and directed sequences pin specific cycle-exact expectations.
module tb_wb_cpu_arbiter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ins_cyc, ins_stb, ins_we;
    logic [3:0]  ins_sel;
    logic [31:0] ins_adr, ins_wdat;
    logic        dat_cyc, dat_stb, dat_we;
    logic [3:0]  dat_sel;
    logic [31:0] dat_adr, dat_wdat;
    logic        mem_ack, mem_stall;
    logic [31:0] mem_rdat;

    logic        o_ins_ack [2];
    logic        o_ins_stall [2];
    logic [31:0] o_ins_rdat [2];
    logic        o_dat_ack [2];
    logic        o_dat_stall [2];
    logic [31:0] o_dat_rdat [2];
    logic        o_mem_cyc [2];
    logic        o_mem_stb [2];
    logic        o_mem_we [2];
    logic [3:0]  o_mem_sel [2];
    logic [31:0] o_mem_adr [2];
    logic [31:0] o_mem_wdat [2];
    logic [1:0]  o_owner [2];

    int total = 0;
    int bad   = 0;

    // model state per instance: 0 idle, 1 ins, 2 dat
    int m_st [2];
    int m_last [2];
    int m_iss [2];
    int m_ret [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wb_cpu_arbiter #(
            .DAT_PRIORITY   (g == 0),
            .MAX_OUTSTANDING(MAXO)
        ) u_dut (
            .clk_i    (clk),
            .rst_i    (rst),
            .ins_cyc  (ins_cyc),
            .ins_stb  (ins_stb),
            .ins_we   (ins_we),
            .ins_sel  (ins_sel),
            .ins_adr  (ins_adr),
            .ins_wdat (ins_wdat),
            .ins_ack  (o_ins_ack[g]),
            .ins_stall(o_ins_stall[g]),
            .ins_rdat (o_ins_rdat[g]),
            .dat_cyc  (dat_cyc),
            .dat_stb  (dat_stb),
            .dat_we   (dat_we),
            .dat_sel  (dat_sel),
            .dat_adr  (dat_adr),
            .dat_wdat (dat_wdat),
            .dat_ack  (o_dat_ack[g]),
            .dat_stall(o_dat_stall[g]),
            .dat_rdat (o_dat_rdat[g]),
            .mem_cyc  (o_mem_cyc[g]),
            .mem_stb  (o_mem_stb[g]),
            .mem_we   (o_mem_we[g]),
            .mem_sel  (o_mem_sel[g]),
            .mem_adr  (o_mem_adr[g]),
            .mem_wdat (o_mem_wdat[g]),
            .mem_ack  (mem_ack),
            .mem_stall(mem_stall),
            .mem_rdat (mem_rdat),
            .owner    (o_owner[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: who owns the bus, how many requests are in flight
    // (issued minus retired), and what each output must therefore be.
    task automatic model_cycle(input int k);
        int          outst;
        bit          own;
        bit          oc, os, ow, e_stb, e_ack, e_stall, ir, dr;
        logic [3:0]  osel;
        logic [31:0] oadr, owd;
        if (rst) begin
            m_st[k] = 0; m_last[k] = 2; m_iss[k] = 0; m_ret[k] = 0;
        end
        outst = m_iss[k] - m_ret[k];
        own = (m_st[k] != 0);
        oc = 0; os = 0; ow = 0; osel = 0; oadr = 0; owd = 0;
        if (m_st[k] == 1) begin
            oc = ins_cyc; os = ins_stb; ow = ins_we; osel = ins_sel; oadr = ins_adr; owd = ins_wdat;
        end else if (m_st[k] == 2) begin
            oc = dat_cyc; os = dat_stb; ow = dat_we; osel = dat_sel; oadr = dat_adr; owd = dat_wdat;
        end
        e_stb   = os && (outst < MAXO);
        e_ack   = own && oc && mem_ack && (outst > 0);
        e_stall = mem_stall || (outst == MAXO);

        chk($sformatf("u%0d.owner", k),     32'(o_owner[k]),     32'(m_st[k]));
        chk($sformatf("u%0d.mem_cyc", k),   32'(o_mem_cyc[k]),   32'(oc));
        chk($sformatf("u%0d.mem_stb", k),   32'(o_mem_stb[k]),   32'(e_stb));
        chk($sformatf("u%0d.mem_we", k),    32'(o_mem_we[k]),    32'(ow));
        chk($sformatf("u%0d.mem_sel", k),   32'(o_mem_sel[k]),   32'(osel));
        chk($sformatf("u%0d.mem_adr", k),   o_mem_adr[k],        oadr);
        chk($sformatf("u%0d.mem_wdat", k),  o_mem_wdat[k],       owd);
        chk($sformatf("u%0d.ins_ack", k),   32'(o_ins_ack[k]),   32'(e_ack && m_st[k] == 1));
        chk($sformatf("u%0d.ins_stall", k), 32'(o_ins_stall[k]), 32'((m_st[k] == 1) ? e_stall : 1'b1));
        chk($sformatf("u%0d.ins_rdat", k),  o_ins_rdat[k],       (m_st[k] == 1) ? mem_rdat : 32'd0);
        chk($sformatf("u%0d.dat_ack", k),   32'(o_dat_ack[k]),   32'(e_ack && m_st[k] == 2));
        chk($sformatf("u%0d.dat_stall", k), 32'(o_dat_stall[k]), 32'((m_st[k] == 2) ? e_stall : 1'b1));
        chk($sformatf("u%0d.dat_rdat", k),  o_dat_rdat[k],       (m_st[k] == 2) ? mem_rdat : 32'd0);

        if (!rst) begin
            if (m_st[k] == 0) begin
                ir = ins_cyc && ins_stb;
                dr = dat_cyc && dat_stb;
                if (ir && dr)  m_st[k] = (k == 0) ? 2 : 3 - m_last[k];
                else if (dr)   m_st[k] = 2;
                else if (ir)   m_st[k] = 1;
            end else if (!oc) begin
                m_last[k] = m_st[k];
                m_st[k] = 0;
                m_iss[k] = 0;
                m_ret[k] = 0;
            end else begin
                if (e_stb && !mem_stall) m_iss[k]++;
                if (e_ack) m_ret[k]++;
            end
        end
    endtask

    // Compare both instances against the model once per cycle, mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) model_cycle(k);
    end

    initial begin
        int grants [4];
        int exp_g [4];
        int acc, mack, seen, maxo, outb, g;
        bit stall_lim;

        exp_g = '{1, 2, 1, 2};
        rst = 1'b1;
        ins_cyc = 0; ins_stb = 0; ins_we = 0; ins_sel = 0; ins_adr = 0; ins_wdat = 0;
        dat_cyc = 0; dat_stb = 0; dat_we = 0; dat_sel = 0; dat_adr = 0; dat_wdat = 0;
        mem_ack = 0; mem_stall = 0; mem_rdat = 0;
        step(); step();
        @(negedge clk);
        chk("rst_mem_cyc", 32'(o_mem_cyc[0]), 32'd0);
        chk("rst_ins_stall", 32'(o_ins_stall[0]), 32'd1);
        chk("rst_dat_stall", 32'(o_dat_stall[1]), 32'd1);
        chk("rst_owner", 32'(o_owner[0]), 32'd0);
        step();
        rst = 1'b0;

        // single read
        ins_cyc = 1; ins_stb = 1; ins_we = 0; ins_adr = 32'h7000_0000;
        @(negedge clk);
        chk("t1_c0_owner", 32'(o_owner[0]), 32'd0);
        step();
        @(negedge clk);
        chk("t1_c1_mem_stb", 32'(o_mem_stb[0]), 32'd1);
        chk("t1_c1_mem_adr", o_mem_adr[0], 32'h7000_0000);
        chk("t1_c1_dat_stall", 32'(o_dat_stall[0]), 32'd1);
        step();
        ins_stb = 0; mem_ack = 1; mem_rdat = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_c2_ins_ack", 32'(o_ins_ack[0]), 32'd1);
        chk("t1_c2_ins_rdat", o_ins_rdat[0], 32'hDEAD_BEEF);
        chk("t1_c2_dat_stall", 32'(o_dat_stall[0]), 32'd1);
        step();
        mem_ack = 0; ins_cyc = 0;
        step(); step();

        // tie with data priority
        mem_stall = 1;
        ins_cyc = 1; ins_stb = 1; ins_adr = 0;
        dat_cyc = 1; dat_stb = 1; dat_we = 1; dat_adr = 32'h100; dat_sel = 4'b0011; dat_wdat = 32'hCAFE;
        step();
        @(negedge clk);
        chk("t2_dat_granted", 32'(o_owner[0]), 32'd2);
        chk("t2_mem_we", 32'(o_mem_we[0]), 32'd1);
        chk("t2_mem_sel", 32'(o_mem_sel[0]), 32'h3);
        chk("t2_mem_adr", o_mem_adr[0], 32'h100);
        chk("t2_ins_stall", 32'(o_ins_stall[0]), 32'd1);
        step();
        dat_cyc = 0; dat_stb = 0; dat_we = 0;
        @(negedge clk);
        chk("t2_mem_cyc_drop", 32'(o_mem_cyc[0]), 32'd0);
        step();
        @(negedge clk);
        chk("t2_idle_bubble", 32'(o_owner[0]), 32'd0);
        step();
        @(negedge clk);
        chk("t2_ins_granted", 32'(o_owner[0]), 32'd1);
        step();
        ins_cyc = 0; ins_stb = 0;
        step(); step();

        // round-robin on ties (instance 1), fresh from reset
        rst = 1;
        step();
        rst = 0;
        ins_cyc = 1; ins_stb = 1; dat_cyc = 1; dat_stb = 1; mem_stall = 1;
        for (int i = 0; i < 4; i++) begin
            g = 0;
            for (int w = 0; w < 10 && g == 0; w++) begin
                step();
                @(negedge clk);
                g = int'(o_owner[1]);
            end
            grants[i] = g;
            chk($sformatf("t3_grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));
            step();
            if (g == 1) begin ins_cyc = 0; ins_stb = 0; end
            else if (g == 2) begin dat_cyc = 0; dat_stb = 0; end
            step();
            ins_cyc = 1; ins_stb = 1; dat_cyc = 1; dat_stb = 1;
        end
        ins_cyc = 0; ins_stb = 0; dat_cyc = 0; dat_stb = 0;
        step(); step(); step();

        // outstanding limit: 6 pipelined reads, first ack late
        acc = 0; mack = 0; seen = 0; maxo = 0; stall_lim = 0;
        ins_cyc = 1; mem_stall = 0;
        for (int c = 0; c < 40 && seen < 6; c++) begin
            ins_stb  = (acc < 6);
            ins_adr  = 32'(c);
            mem_ack  = (c >= 6) && (acc > mack);
            mem_rdat = 32'(mack);
            @(negedge clk);
            outb = acc - seen;
            if (outb == 4 && o_ins_stall[0]) stall_lim = 1;
            if (o_ins_ack[0]) begin
                chk("t4_order", o_ins_rdat[0], 32'(seen));
                seen++;
            end
            if (o_mem_stb[0] && !mem_stall) acc++;
            if (mem_ack) mack++;
            if (acc - seen > maxo) maxo = acc - seen;
            step();
        end
        chk("t4_acks", 32'(seen), 32'd6);
        chk("t4_max_outstanding", 32'(maxo), 32'd4);
        chk("t4_stall_at_limit", 32'(stall_lim), 32'd1);
        ins_cyc = 0; ins_stb = 0; mem_ack = 0;
        step(); step();

        // abort with two outstanding while ins waits
        ins_cyc = 1; ins_stb = 1; ins_adr = 32'h40;
        dat_cyc = 1; dat_stb = 1; dat_we = 0; dat_adr = 32'h200;
        mem_stall = 0; mem_ack = 0;
        step();
        @(negedge clk);
        chk("t5_dat_owner", 32'(o_owner[0]), 32'd2);
        step();
        step();
        dat_cyc = 0; dat_stb = 0;
        @(negedge clk);
        chk("t5_mem_cyc_abort", 32'(o_mem_cyc[0]), 32'd0);
        step();
        mem_ack = 1; mem_rdat = 32'h1111_1111;
        @(negedge clk);
        chk("t5_idle", 32'(o_owner[0]), 32'd0);
        chk("t5_ack1_ins", 32'(o_ins_ack[0]), 32'd0);
        chk("t5_ack1_dat", 32'(o_dat_ack[0]), 32'd0);
        step();
        mem_rdat = 32'h2222_2222;
        @(negedge clk);
        chk("t5_ins_owner", 32'(o_owner[0]), 32'd1);
        chk("t5_ack2_ins", 32'(o_ins_ack[0]), 32'd0);
        chk("t5_ack2_dat", 32'(o_dat_ack[0]), 32'd0);
        step();
        mem_ack = 0; ins_cyc = 0; ins_stb = 0;
        step(); step();

        // reset in the middle of an ins burst
        ins_cyc = 1; ins_stb = 1; mem_stall = 0; mem_ack = 0;
        step(); step(); step();
        #2 rst = 1;
        #1;
        chk("t6_mem_cyc0", 32'(o_mem_cyc[0]), 32'd0);
        chk("t6_mem_cyc1", 32'(o_mem_cyc[1]), 32'd0);
        chk("t6_owner", 32'(o_owner[0]), 32'd0);
        chk("t6_ins_stall", 32'(o_ins_stall[0]), 32'd1);
        @(negedge clk);
        step();
        rst = 0; ins_cyc = 0; ins_stb = 0;
        @(negedge clk);
        chk("t6_ins_stall_after", 32'(o_ins_stall[0]), 32'd1);
        chk("t6_dat_stall_after", 32'(o_dat_stall[0]), 32'd1);
        step();

        // random traffic, including spurious acks and bus locks
        for (int c = 0; c < 3000; c++) begin
            if (!ins_cyc) ins_cyc = ($urandom_range(3) == 0);
            else          ins_cyc = ($urandom_range(7) != 0);
            ins_stb  = ins_cyc && ($urandom_range(3) != 0);
            ins_we   = 1'($urandom_range(1));
            ins_sel  = 4'($urandom);
            ins_adr  = $urandom;
            ins_wdat = $urandom;
            if (!dat_cyc) dat_cyc = ($urandom_range(3) == 0);
            else          dat_cyc = ($urandom_range(7) != 0);
            dat_stb  = dat_cyc && ($urandom_range(3) != 0);
            dat_we   = 1'($urandom_range(1));
            dat_sel  = 4'($urandom);
            dat_adr  = $urandom;
            dat_wdat = $urandom;
            mem_ack   = 1'($urandom_range(1));
            mem_stall = ($urandom_range(2) == 0);
            mem_rdat  = $urandom;
            step();
        end

        ins_cyc = 0; ins_stb = 0; dat_cyc = 0; dat_stb = 0; mem_ack = 0;
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
